// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between stopwatch_ctrl and its neighbours (clkdiv, debounce, counter, 7-seg driver).
// master = the controller side; slave = the environment driving ticks/buttons and consuming strobes.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_adj;
  logic       btn_pause;
  logic       adj_sw;
  logic [1:0] sel;
  logic [3:0] num;
  logic       inc;
  logic       load;
  logic [1:0] load_sel;
  logic [3:0] load_val;
  logic       running;
  logic [3:0] blank;
  logic [1:0] state;

  modport master (
    input  tick_1hz, tick_adj, btn_pause, adj_sw, sel, num,
    output inc, load, load_sel, load_val, running, blank, state
  );

  modport slave (
    output tick_1hz, tick_adj, btn_pause, adj_sw, sel, num,
    input  inc, load, load_sel, load_val, running, blank, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM: IDLE/RUN/PAUSE/ADJUST, one-cycle inc/load strobes, run flag, adjust blink mask.
// Optional load_val clamping to legal digit ranges with `define STOPWATCH_CTRL_CLAMP_EN.
module stopwatch_ctrl #(
  parameter int DIGIT_MAX = 9,
  parameter int TENS_MAX  = 5,
  parameter int BLINK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } state_t;

`ifdef STOPWATCH_CTRL_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [3:0] ONES_LIM   = 4'(DIGIT_MAX);
  localparam logic [3:0] TENS_LIM   = 4'(TENS_MAX);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_DIV - 1);

  state_t     st;
  logic       btn_q;
  logic       inc_q;
  logic       load_q;
  logic [1:0] lsel_q;
  logic [3:0] lval_q;
  logic       run_q;
  logic [3:0] blank_q;
  logic       phase;
  logic [3:0] bcnt;

  logic       press;
  logic [3:0] sel_mask;
  logic [3:0] num_fix;

  function automatic logic [3:0] clamp_val(input logic [1:0] s, input logic [3:0] n);
    logic [3:0] lim;
    lim = s[0] ? TENS_LIM : ONES_LIM;
    return (n > lim) ? lim : n;
  endfunction

  assign press    = bus.btn_pause & ~btn_q;
  assign sel_mask = 4'b0001 << bus.sel;
  assign num_fix  = CLAMP_EN ? clamp_val(bus.sel, bus.num) : bus.num;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      btn_q   <= 1'b1;
      inc_q   <= 1'b0;
      load_q  <= 1'b0;
      lsel_q  <= 2'd0;
      lval_q  <= 4'd0;
      run_q   <= 1'b0;
      blank_q <= 4'd0;
      phase   <= 1'b0;
      bcnt    <= 4'd0;
    end else begin
      btn_q  <= bus.btn_pause;
      // Strobes use the state before this cycle's transition.
      inc_q  <= bus.tick_1hz && (st == RUN);
      load_q <= bus.tick_adj && (st == ADJUST);
      if (bus.tick_adj && (st == ADJUST)) begin
        lsel_q <= bus.sel;
        lval_q <= num_fix;
      end

      if (bus.adj_sw) begin
        st    <= ADJUST;
        run_q <= 1'b0;
        if ((st == ADJUST) && bus.tick_adj) begin
          if (bcnt == BLINK_LAST) begin
            bcnt    <= 4'd0;
            phase   <= ~phase;
            blank_q <= phase ? 4'd0 : sel_mask;
          end else begin
            bcnt    <= bcnt + 4'd1;
            blank_q <= phase ? sel_mask : 4'd0;
          end
        end else begin
          blank_q <= phase ? sel_mask : 4'd0;
        end
      end else begin
        phase   <= 1'b0;
        bcnt    <= 4'd0;
        blank_q <= 4'd0;
        case (st)
          IDLE: begin
            run_q <= press;
            if (press) st <= RUN;
          end
          RUN: begin
            run_q <= ~press;
            if (press) st <= PAUSE;
          end
          PAUSE: begin
            run_q <= press;
            if (press) st <= RUN;
          end
          default: begin
            // Leaving adjust always parks in PAUSE; the user resumes explicitly.
            run_q <= 1'b0;
            st    <= PAUSE;
          end
        endcase
      end
    end
  end

  assign bus.inc      = inc_q;
  assign bus.load     = load_q;
  assign bus.load_sel = lsel_q;
  assign bus.load_val = lval_q;
  assign bus.running  = run_q;
  assign bus.blank    = blank_q;
  assign bus.state    = st;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode controller for the 4-digit MM:SS stopwatch. It sequences the digit counter from debounced button levels, the adjust switch and divided-clock ticks. It emits one-cycle increment and load strobes, a run flag and a blink mask for the 7-segment driver. It sits between the debounce/clkdiv instances and the counter, and replaces the ad-hoc paused/adj_sel glue in top.

Parameters:
DIGIT_MAX, 9, maximum value for ones digits (sel 0 and 2)
TENS_MAX, 5, maximum value for tens digits (sel 1 and 3)
BLINK_DIV, 2, tick_adj pulses per blink phase toggle (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick_1hz  in  1  one-cycle pulse, 1 Hz, from clkdiv
tick_adj  in  1  one-cycle pulse, 5 Hz, from clkdiv
btn_pause  in  1  debounced level, pause/run button
adj_sw  in  1  adjust-mode switch level
sel  in  2  digit select: 0=sec ones, 1=sec tens, 2=min ones, 3=min tens
num  in  4  value to load in adjust mode
inc  out  1  one-cycle count strobe to counter
load  out  1  one-cycle digit load strobe
load_sel  out  2  digit index for load
load_val  out  4  value for load
running  out  1  high in RUN
blank  out  4  per-digit blank mask (bit i = digit i off)
state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=ADJUST

Behaviour:
- All logic is on posedge clk. rst is synchronous and active-high, and has top priority.
- Reset values: state=IDLE. inc, load, running=0. load_sel=0, load_val=0, blank=0. Edge register=1, so a button held through reset does not trigger. Blink phase=0 and blink count=0.
- Press event: rising edge of btn_pause (registered previous level 0, current level 1). Single-cycle, detected one cycle after the level rises.
- State transitions, in priority order:
  - adj_sw=1 in any state goes to ADJUST on the next cycle.
  - In ADJUST, adj_sw=0 goes to PAUSE; the count is never auto-resumed.
  - IDLE with a press goes to RUN.
  - RUN with a press goes to PAUSE.
  - PAUSE with a press goes to RUN.
  - Presses while in ADJUST are ignored, not queued.
- inc: registered, asserted exactly one cycle after tick_1hz sampled while state==RUN. A tick on the same cycle as a press leaving RUN still produces inc; state is sampled before the update. No inc in any other state.
- load: in ADJUST, each tick_adj produces a load pulse one cycle later, with load_sel=sel and load_val=num (clamped; see Optional Feature). Sel/num changes take effect at the next tick_adj only.
- running: equals (state==RUN).
- Blink:
  - In ADJUST, a count increments on tick_adj. At BLINK_DIV it wraps to 0 and toggles phase.
  - blank = one-hot(sel) when phase=1, otherwise 0.
  - Leaving ADJUST clears phase, count and blank on the same transition cycle.
- The counter's own zeroing is driven by rst; this block issues no clear strobe.
- inc and load are never asserted in the same cycle.

Optional Feature:
Macro: STOPWATCH_CTRL_CLAMP_EN.
- Defined: load_val = min(num, DIGIT_MAX) for sel 0/2 and min(num, TENS_MAX) for sel 1/3. For example num=12 on sel=1 gives load_val=5.
- Undefined: load_val = num unmodified. The counter is then responsible for illegal values.

Test Plan:
- Reset with btn_pause held high, release, press again -> first press after release gives state IDLE->RUN. No transition from the held level.
- RUN with 3 tick_1hz pulses -> exactly 3 inc pulses, each 1 cycle after its tick. Press then 2 ticks -> state=PAUSE, 0 further inc.
- tick_1hz on the same cycle the press is detected in RUN -> one inc emitted, state=PAUSE next cycle.
- In RUN, adj_sw=1, sel=2, num=7, then 2 tick_adj -> state=ADJUST, 2 load pulses with load_sel=2 and load_val=7, no inc. blank=4'b0100 after BLINK_DIV ticks, 0 after the next BLINK_DIV.
- ADJUST with adj_sw=0 -> state=PAUSE and blank=0 the same cycle. Press -> RUN.
- CLAMP_EN defined, ADJUST, sel=3, num=9, tick_adj -> load_val=5. Undefined -> load_val=9.
